// File: rtl/ysyx_23060061_lsu.sv
// ysyx_23060061_lsu: multi-cycle load/store unit between the execute stage
// and the data-memory bus. One access in flight at a time, valid/ready on
// both sides, with misalignment detection, a bus timeout and draining of the
// late response that belongs to a timed-out access.
module ysyx_23060061_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t state, state_next;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [NB-1:0]     wstrb_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [XLEN-1:0]   rdata_q;
  logic [1:0]        err_q;
  logic [CNT_W-1:0]  cnt;
  logic              orphan;

  logic              accept;
  logic              aligned;
  logic              timed_out;
  logic              rsp_take;
  logic [OFF_W-1:0]  req_off;
  logic [7:0]        size_bytes;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   load_mask;
  logic [XLEN-1:0]   load_data;
  logic              load_sign;

  assign req_ready = (state == IDLE) && rst;
  assign accept    = req_valid && req_ready;
  assign req_off   = req_addr[OFF_W-1:0];
  assign timed_out = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
  assign rsp_take  = (state == WAIT) && mem_rsp_valid && !orphan;

  assign mem_req_valid = (state == REQ);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign rsp_valid     = (state == RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;

  // Alignment check and byte-count mask for the incoming request; a double on a 32-bit core is never aligned.
  always_comb begin
    aligned    = 1'b0;
    size_bytes = 8'h01;
    case (req_size)
      2'd0: begin
        aligned    = 1'b1;
        size_bytes = 8'h01;
      end
      2'd1: begin
        aligned    = ~req_addr[0];
        size_bytes = 8'h03;
      end
      2'd2: begin
        aligned    = (req_addr[1:0] == 2'b00);
        size_bytes = 8'h0F;
      end
      default: begin
        aligned    = (XLEN == 64) && (req_addr[2:0] == 3'b000);
        size_bytes = 8'hFF;
      end
    endcase
  end

  // Right-align the addressed lanes of the bus word, then mask and extend to the access size.
  always_comb begin
    shifted   = mem_rsp_rdata >> {off_q, 3'b000};
    load_mask = '1;
    load_sign = shifted[XLEN-1];
    case (size_q)
      2'd0: begin
        load_mask = XLEN'(8'hFF);
        load_sign = shifted[7];
      end
      2'd1: begin
        load_mask = XLEN'(16'hFFFF);
        load_sign = shifted[15];
      end
      2'd2: begin
        load_mask = XLEN'(32'hFFFF_FFFF);
        load_sign = shifted[31];
      end
      default: begin
        load_mask = '1;
        load_sign = shifted[XLEN-1];
      end
    endcase
    load_data = (shifted & load_mask) | ((!uns_q && load_sign) ? ~load_mask : '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a timeout beats a late handshake in REQ, a real response beats the timeout in WAIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = aligned ? REQ : RESP;
      REQ: begin
        if (timed_out)          state_next = RESP;
        else if (mem_req_ready) state_next = WAIT;
      end
      WAIT: if (rsp_take || timed_out) state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, bus-side lane steering, timeout counter, result capture and orphan tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 2'b00;
      cnt     <= '0;
      orphan  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            off_q   <= req_off;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= aligned ? 2'b00 : 2'b01;
            if (aligned) begin
              we_q    <= req_wen;
              addr_q  <= req_addr & ~ADDR_W'(NB - 1);
              wdata_q <= req_wdata << {req_off, 3'b000};
              wstrb_q <= req_wen ? (NB'(size_bytes) << req_off) : '0;
            end
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (timed_out) err_q <= 2'b11;
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (rsp_take) begin
            rdata_q <= (we_q || mem_rsp_err) ? '0 : load_data;
            err_q   <= mem_rsp_err ? 2'b10 : 2'b00;
          end else if (timed_out) begin
            err_q <= 2'b11;
          end
        end
        default: ;
      endcase

      if ((state == REQ) && timed_out && mem_req_ready) begin
        orphan <= 1'b1;
      end else if ((state == WAIT) && timed_out && !rsp_take) begin
        orphan <= 1'b1;
      end else if (mem_rsp_valid && orphan) begin
        orphan <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_lsu.sv
// tb_ysyx_23060061_lsu: directed and randomized accesses against a
// byte-level reference model of the LSU, driving a scripted bus.
module tb_ysyx_23060061_lsu;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  ysyx_23060061_lsu #(
    .XLEN(32),
    .ADDR_W(32),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen(req_wen),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    checkOutput({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
  endtask

  // One complete access: handshake, scripted bus, response hold, release.
  // rd: cycles mem_req_ready stays low; sd: cycles between acceptance and response;
  // rr: cycles rsp_ready stays low; never_rsp: bus accepts but stays silent;
  // orphan_first: a stale response pulse arrives before the real one.
  task automatic applyStimulus(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic uns, input int rd, input int sd,
                               input logic berr, input logic [31:0] bdata, input int rr,
                               input logic never_rsp, input logic orphan_first,
                               input logic [31:0] orphan_data);
    int          off;
    int          nbytes;
    int          acc;
    int          orph_cyc;
    int          rsp_cyc;
    int          resp_cyc;
    int          req_end;
    logic        al;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    logic [1:0]  exp_err;
    longint      val;

    off    = int'(addr % 32'd4);
    nbytes = 1 << size;
    al     = (size != 2'd3) && ((off % nbytes) == 0);

    exp_addr  = addr - 32'(off);
    exp_strb  = '0;
    exp_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (wen && i >= off && i < off + nbytes) exp_strb[i] = 1'b1;
      if (i >= off) exp_wdata[8*i +: 8] = wdata[8*(i-off) +: 8];
    end

    val = 0;
    if (al) begin
      for (int j = 0; j < nbytes; j++) val += longint'(bdata[8*(off+j) +: 8]) << (8*j);
      if (!uns && val >= (longint'(1) << (8*nbytes - 1))) val -= (longint'(1) << (8*nbytes));
    end
    exp_rdata = (wen || berr || never_rsp || !al) ? 32'h0 : val[31:0];
    if (!al)            exp_err = 2'b01;
    else if (never_rsp) exp_err = 2'b11;
    else if (berr)      exp_err = 2'b10;
    else                exp_err = 2'b00;

    acc      = 1 + rd;
    orph_cyc = orphan_first ? acc + 1 : -1;
    rsp_cyc  = orphan_first ? acc + 2 + sd : acc + 1 + sd;
    if (!al)            resp_cyc = 1;
    else if (never_rsp) resp_cyc = TO + 2;
    else                resp_cyc = rsp_cyc + 1;
    req_end = (acc < TO + 1) ? acc : TO + 1;

    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
    tick();
    req_valid    = 1'b0;
    req_wen      = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);

    for (int cyc = 1; cyc < resp_cyc; cyc++) begin
      checkOutput("rsp_valid_busy", 32'(rsp_valid), 32'd0);
      checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
      checkOutput("mem_req_valid", 32'(mem_req_valid), 32'(cyc <= req_end));
      if (cyc <= req_end) begin
        checkOutput("mem_addr", mem_addr, exp_addr);
        checkOutput("mem_we", 32'(mem_we), 32'(wen));
        checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
        if (wen) checkOutput("mem_wdata", mem_wdata, exp_wdata);
      end
      mem_req_ready = (cyc == acc);
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = $urandom;
      mem_rsp_err   = 1'b0;
      if (!never_rsp && cyc == rsp_cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = bdata;
        mem_rsp_err   = berr;
      end
      if (cyc == orph_cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = orphan_data;
      end
      tick();
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
    end

    for (int k = 0; k <= rr; k++) begin
      checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
      checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
      checkOutput("mem_req_valid_resp", 32'(mem_req_valid), 32'd0);
      checkOutput("req_ready_resp", 32'(req_ready), 32'd0);
      rsp_ready = (k == rr);
      tick();
    end
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst           = 1'b0;
    req_valid     = 1'b0;
    req_wen       = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    req_size      = '0;
    req_unsigned  = 1'b0;
    rsp_ready     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    mem_rsp_err   = 1'b0;

    #1;
    checkResetValues("por");
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("req_ready_after_reset", 32'(req_ready), 32'd1);

    // signed / unsigned byte loads from the top lane
    applyStimulus(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 0, 0, 1'b0, 32'h80FF_1234, 0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 0, 0, 1'b0, 32'h80FF_1234, 0, 1'b0, 1'b0, 32'h0);
    // halfword store into the upper lanes
    applyStimulus(1'b1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 1'b0, 0, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0);
    // misaligned word and a double on a 32-bit core
    applyStimulus(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 0, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h8000_0000, 32'h1234_5678, 2'd3, 1'b0, 0, 0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0);
    // slow bus acceptance, slow consumer, bus error
    applyStimulus(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 3, 1, 1'b1, 32'hCAFE_F00D, 2, 1'b0, 1'b0, 32'h0);

    // stray bus response while idle must be ignored
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hBAD0_BAD0;
    tick();
    mem_rsp_valid = 1'b0;
    applyStimulus(1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0, 0, 0, 1'b0, 32'h0BAD_CAFE, 0, 1'b0, 1'b0, 32'h0);

    // timeout in WAIT, then the late response must be drained
    applyStimulus(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 0, 0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 0, 0, 1'b0, 32'h1234_5678, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // timeout in REQ leaves nothing to drain
    applyStimulus(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 100, 0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h8000_0004, 32'h0, 2'd1, 1'b0, 0, 0, 1'b0, 32'h0000_8001, 0, 1'b0, 1'b0, 32'h0);

    // reset while waiting on the bus, with an orphan pending from a timeout
    applyStimulus(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 0, 0, 1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h0);
    req_valid    = 1'b1;
    req_wen      = 1'b0;
    req_addr     = 32'h8000_0000;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
    tick();
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checkOutput("wait_before_reset", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    checkResetValues("mid_reset");
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    applyStimulus(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 0, 0, 1'b0, 32'h0000_0055, 0, 1'b0, 1'b0, 32'h0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'($urandom), 32'h8000_0000 + $urandom_range(63, 0), $urandom,
                    2'($urandom_range(3, 0)), 1'($urandom), $urandom_range(3, 0),
                    $urandom_range(3, 0), ($urandom_range(5, 0) == 0), $urandom,
                    $urandom_range(2, 0), 1'b0, 1'b0, 32'h0);
      if ($urandom_range(1, 0) == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_lsu.md
# ysyx_23060061_lsu

Parametrised load/store unit between the execute stage and the data-memory bus of the ysyx_23060061 core. It replaces the zero-latency combinational memory access with a multi-cycle valid/ready engine. The engine supports XLEN 32 or 64, byte/half/word(/double) accesses, sign or zero extension, byte-lane steering and strobes, misalignment detection, and a bus timeout with orphan-response draining. One transaction is outstanding at a time.

## Interface
- XLEN, 32: data width, 32 or 64.
- ADDR_W, 32: address width.
- TIMEOUT, 256: max cycles spent in REQ+WAIT before abort; 0 disables timeout.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- req_valid  in  1  access request from EXU.
- req_ready  out  1  LSU can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- req_size  in  2  0 byte, 1 half, 2 word, 3 double (XLEN=64 only).
- req_unsigned  in  1  load zero-extends when 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  EXU/WB accepts result.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 bus error, 11 timeout.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts request.
- mem_we  out  1  bus write.
- mem_addr  out  ADDR_W  req_addr with low log2(XLEN/8) bits cleared.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wstrb  out  XLEN/8  byte strobes; all 0 for reads.
- mem_rsp_valid  in  1  bus response, one-cycle pulse.
- mem_rsp_rdata  in  XLEN  full-width read data.
- mem_rsp_err  in  1  bus error flag, valid with mem_rsp_valid.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. Reset state is IDLE.
- In IDLE, req_ready = 1 (forced 0 while rst = 0). A handshake registers all req_* fields.
  - If aligned (addr mod 2^size == 0, and size 3 only when XLEN=64): next state REQ.
  - Otherwise: next state RESP with err 01 and no bus activity. size 3 with XLEN=32 counts as misaligned.
- REQ: mem_req_valid = 1, all mem_* outputs held stable until mem_req_ready, then WAIT.
- WAIT: on mem_rsp_valid, go to RESP.
  - Loads capture rdata = mem_rsp_rdata >> (8*off), masked to size and extended per req_unsigned.
  - err = mem_rsp_err ? 10 : 00. On a bus error, rsp_rdata = 0.
- RESP: rsp_valid = 1, rsp_rdata and rsp_err held until rsp_ready, then IDLE. No new request is accepted in the same cycle.
- Lane steering (off = addr[log2(XLEN/8)-1:0]):
  - mem_wdata = req_wdata << (8*off).
  - mem_wstrb = ((1 << 2^size) - 1) << off, stores only.
- Timeout counter:
  - Clears on entering REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT: go to RESP with err 11 and drop mem_req_valid.
  - If the abort happens in WAIT, set flag orphan. If it happens in REQ, the request was never accepted, so orphan stays clear.
- orphan = 1: the next mem_rsp_valid, in any state, is discarded and clears orphan. A response coinciding with a WAIT for a new request is consumed as the orphan, not as the new response.
- mem_rsp_valid outside WAIT with orphan = 0 is ignored.

## Timing
- Reset values: req_ready 0 (during reset) then 1; rsp_valid 0, rsp_rdata 0, rsp_err 00, mem_req_valid 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_wstrb 0, orphan 0, counter 0.
- All outputs except req_ready are registered or decoded from registered state.
- Aligned access with zero-wait bus: handshake at cycle 0, mem_req_valid at cycle 1. mem_rsp_valid is sampled from cycle 2, so the earliest rsp_valid is cycle 3.
- Misaligned access: rsp_valid at cycle 1.
- Throughput: at most one access per 2 cycles (RESP → IDLE → accept).
- Timeout fires in the cycle the counter equals TIMEOUT; rsp_valid appears the following cycle.
- Reset asserted in any state aborts immediately to reset values.
  - Any in-flight bus transaction is forgotten, and orphan is cleared.
  - The bus side must also be reset.

## Test plan
- XLEN=32, signed lb at 0x80000003, bus returns 0x80FF1234 → mem_addr 0x80000000, mem_wstrb 0000, rsp_rdata 0x00000080? No: byte 3 = 0x80, so rsp_rdata 0xFFFFFF80. With lbu, rsp_rdata 0x00000080. err 00.
- sh at 0x80000002, wdata 0x0000ABCD → mem_we 1, mem_wdata 0xABCD0000, mem_wstrb 1100; rsp_rdata 0, err 00.
- lw at 0x80000002 → mem_req_valid never asserted; rsp_valid at cycle 1, err 01; sd on XLEN=32 also gives err 01.
- TIMEOUT=8, bus accepts the request but never responds → rsp err 11 after 8 cycles. The next lw to 0x80000000 discards the first late mem_rsp_valid (0xDEADBEEF) and returns the second (0x12345678).
- mem_req_ready low 3 cycles, then rsp_ready low 2 cycles → mem_* and rsp_* stable throughout, req_ready 0 until the cycle after the rsp handshake; mem_rsp_err=1 gives err 10, rdata 0.
- rst driven 0 while in WAIT → all outputs at reset values immediately; after release, lw at 0x80000004 returning 0x00000055 yields rsp_rdata 0x00000055, err 00.
